c64_bus_sequencer: RTL and testbench

Cycle-level bus sequencer for the GM64 core, clocked by the PAL dot clock (7.881984 MHz) from the master clock generator. It divides the dot clock into C64 CPU cycles (8 dots each) and produces phi2 and the CPU/VIC clock-enable strobes. It arbitrates each half-cycle of the shared RAM bus between VIC-II and CPU, including the BA→AEC three-cycle steal delay and RDY handling. It holds the whole bus idle until the dot-clock PLL has been stably locked.

---
 rtl/gm64_bus_pkg.sv | 9 +
 rtl/ba_aec_tracker.sv | 28 ++
 rtl/c64_bus_sequencer.sv | 71 +++++++
 tb/tb_c64_bus_sequencer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/gm64_bus_pkg.sv
// gm64_bus_pkg: bus owner codes, sequencer state type and default timing parameters
package gm64_bus_pkg;
  localparam logic [1:0] OWNER_IDLE = 2'd0;
  localparam logic [1:0] OWNER_VIC = 2'd1;
  localparam logic [1:0] OWNER_CPU = 2'd2;
  localparam int DEF_DOTS_PER_CYCLE = 8;
  localparam int DEF_BA_DELAY = 3;
  typedef enum logic {WAIT_LOCK, RUN} seq_state_t;
endpackage

// File: rtl/ba_aec_tracker.sv
// ba_aec_tracker: BA low-cycle counter with rdy/aec registers (clk, rst, clr, eoc strobe, ba in; aec, rdy out)
module ba_aec_tracker #(
  parameter int BA_DELAY = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic eoc,
  input  logic ba,
  output logic aec,
  output logic rdy
);
  localparam int BW = $clog2(BA_DELAY + 1);
  localparam logic [BW-1:0] BMAX = BW'(BA_DELAY);
  logic [BW-1:0] cnt, cnt_next;
  assign cnt_next = ba ? '0 : cnt == BMAX ? cnt : cnt + BW'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      cnt <= '0;
      aec <= 1'b1;
      rdy <= 1'b1;
    end else if (eoc) begin
      cnt <= cnt_next;
      aec <= cnt_next < BMAX;
      rdy <= ba;
    end
  end
endmodule

// File: rtl/c64_bus_sequencer.sv
// c64_bus_sequencer: dot-clock CPU cycle sequencer (clkDot, reset, pllLocked, ba, rw in; phi2, vicEnable, cpuEnable, aec, rdy, busOwner, ramStrobe, cycleCount out)
module c64_bus_sequencer
  import gm64_bus_pkg::*;
#(
  parameter int DOTS_PER_CYCLE = DEF_DOTS_PER_CYCLE,
  parameter int LOCK_WAIT = 16,
  parameter int BA_DELAY = DEF_BA_DELAY
) (
  input  logic        clkDot,
  input  logic        reset,
  input  logic        pllLocked,
  input  logic        ba,
  input  logic        rw,
  output logic        phi2,
  output logic        vicEnable,
  output logic        cpuEnable,
  output logic        aec,
  output logic        rdy,
  output logic [1:0]  busOwner,
  output logic        ramStrobe,
  output logic [15:0] cycleCount
);
  localparam int DW = $clog2(DOTS_PER_CYCLE);
  localparam int LW = $clog2(LOCK_WAIT + 1);
  localparam logic [DW-1:0] LAST = DW'(DOTS_PER_CYCLE - 1);
  localparam logic [DW-1:0] PRE_LAST = DW'(DOTS_PER_CYCLE - 2);
  localparam logic [DW-1:0] HALF = DW'(DOTS_PER_CYCLE / 2);
  localparam logic [DW-1:0] VIC_DOT = DW'(DOTS_PER_CYCLE / 2 - 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_WAIT);
  logic [1:0] sync;
  logic [LW-1:0] lock_cnt;
  logic [DW-1:0] dot;
  seq_state_t state;
  logic run, live, eoc;
  assign run = state == RUN;
  assign live = run && sync[1];
  assign eoc = live && dot == LAST;
  always_ff @(posedge clkDot or posedge reset) begin
    if (reset) begin
      sync <= '0;
      lock_cnt <= '0;
      state <= WAIT_LOCK;
      dot <= '0;
      cycleCount <= '0;
      cpuEnable <= 1'b0;
    end else begin
      sync <= {sync[0], pllLocked};
      lock_cnt <= !sync[1] ? '0 : lock_cnt == LOCK_MAX ? lock_cnt : lock_cnt + LW'(1);
      state <= sync[1] && (run || lock_cnt >= LOCK_MAX - LW'(1)) ? RUN : WAIT_LOCK;
      dot <= live && dot != LAST ? dot + DW'(1) : '0;
      cycleCount <= live ? cycleCount + 16'(eoc) : '0;
      // registered one dot early so the strobe carries no combinational path from rw
      cpuEnable <= live && dot == PRE_LAST && aec && (rdy || !rw);
    end
  end
  ba_aec_tracker #(.BA_DELAY(BA_DELAY)) u_tracker (
    .clk(clkDot),
    .rst(reset),
    .clr(!live),
    .eoc(eoc),
    .ba(ba),
    .aec(aec),
    .rdy(rdy)
  );
  always_comb begin
    phi2 = run && dot >= HALF;
    vicEnable = run && dot == VIC_DOT;
    ramStrobe = run && (dot == '0 || dot == HALF);
    busOwner = !run ? OWNER_IDLE : (dot < HALF || !aec) ? OWNER_VIC : OWNER_CPU;
  end
endmodule

// File: tb/tb_c64_bus_sequencer.sv
// tb_c64_bus_sequencer: scoreboard bench for c64_bus_sequencer
module tb_c64_bus_sequencer;
  typedef struct packed {
    logic phi2;
    logic vic;
    logic cpu;
    logic aec;
    logic rdy;
    logic [1:0] owner;
    logic ram;
    logic [15:0] cnt;
  } exp_t;
  localparam exp_t IDLE = '{phi2: 1'b0, vic: 1'b0, cpu: 1'b0, aec: 1'b1, rdy: 1'b1, owner: 2'd0, ram: 1'b0, cnt: 16'd0};
  logic clkDot = 1'b0;
  logic reset = 1'b1;
  logic pllLocked = 1'b1;
  logic ba = 1'b1;
  logic rw = 1'b1;
  logic phi2, vicEnable, cpuEnable, aec, rdy, ramStrobe;
  logic [1:0] busOwner;
  logic [15:0] cycleCount;
  exp_t q[$];
  logic [15:0] exp_cnt = 16'd0;
  int n_chk = 0;
  int n_pass = 0;
  c64_bus_sequencer dut (
    .clkDot(clkDot),
    .reset(reset),
    .pllLocked(pllLocked),
    .ba(ba),
    .rw(rw),
    .phi2(phi2),
    .vicEnable(vicEnable),
    .cpuEnable(cpuEnable),
    .aec(aec),
    .rdy(rdy),
    .busOwner(busOwner),
    .ramStrobe(ramStrobe),
    .cycleCount(cycleCount)
  );
  always #5 clkDot = ~clkDot;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask
  always @(negedge clkDot) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("phi2", 32'(phi2), 32'(e.phi2));
      check("vicEnable", 32'(vicEnable), 32'(e.vic));
      check("cpuEnable", 32'(cpuEnable), 32'(e.cpu));
      check("aec", 32'(aec), 32'(e.aec));
      check("rdy", 32'(rdy), 32'(e.rdy));
      check("busOwner", 32'(busOwner), 32'(e.owner));
      check("ramStrobe", 32'(ramStrobe), 32'(e.ram));
      check("cycleCount", 32'(cycleCount), 32'(e.cnt));
    end
  end
  task automatic step();
    @(posedge clkDot);
    #1;
  endtask
  task automatic wait_lock();
    pllLocked = 1'b1;
    repeat (18) begin
      q.push_back(IDLE);
      step();
    end
  endtask
  // mode: 0 plain, 1 ba glitch mid-cycle, 2 pll drop at dot 5, 3 counter preload to 0xFFFF
  task automatic cyc(input logic b, input logic w, input logic a, input logic r, input int mode);
    exp_t e;
    for (int d = 0; d < 8; d++) begin
      ba = (mode == 1 && d >= 2 && d <= 5) ? 1'b0 : b;
      rw = w;
      if (mode == 2 && d == 5) pllLocked = 1'b0;
      if (mode == 3 && d == 0) begin
        force dut.cycleCount = 16'hFFFF;
        #1;
        release dut.cycleCount;
        exp_cnt = 16'hFFFF;
      end
      e = '{phi2: d >= 4, vic: d == 3, cpu: d == 7 && a && (r || !w), aec: a, rdy: r,
            owner: (d < 4 || !a) ? 2'd1 : 2'd2, ram: d == 0 || d == 4, cnt: exp_cnt};
      q.push_back(e);
      step();
    end
    exp_cnt = mode == 2 ? 16'd0 : exp_cnt + 16'd1;
  endtask
  initial begin
    step();
    q.push_back(IDLE);
    step();
    reset = 1'b0;
    wait_lock();
    repeat (3) cyc(1, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 0);
    cyc(1, 1, 1, 1, 1);
    cyc(1, 1, 1, 1, 0);
    cyc(1, 1, 1, 1, 3);
    cyc(1, 1, 1, 1, 0);
    cyc(1, 1, 1, 1, 2);
    wait_lock();
    cyc(1, 1, 1, 1, 0);
    cyc(1, 1, 1, 1, 0);
    reset = 1'b1;
    exp_cnt = 16'd0;
    q.push_back(IDLE);
    step();
    reset = 1'b0;
    wait_lock();
    cyc(1, 1, 1, 1, 0);
    @(negedge clkDot);
    #1;
    check("drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
